// File: rtl/uno_pkg.sv
// Shared types, constants and fixed-point helpers for the uno_horner PE.
// UNO_HORNER_ROUND_EN selects round-half-up instead of truncation on every >>>FRAC.
package uno_pkg;

    typedef enum logic [1:0] {
        OP_MAC = 2'd0,
        OP_DIV = 2'd1,
        OP_EXP = 2'd2,
        OP_LOG = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_HORNER = 3'd2,
        S_SCALE  = 3'd3,
        S_EXEC   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // ln(2) in Q.30 and e, 1/e in Q.20; narrower formats are derived from these
    localparam longint LN2_Q30  = 64'sd744261118;
    localparam int     EXP_Q    = 32'sd20;
    localparam longint E_QE     = 64'sd2850325;
    localparam longint INV_E_QE = 64'sd385749;

    function automatic longint three_quarters(input int frac);
        return 64'sd3 <<< (frac - 32'sd2);
    endfunction

    function automatic longint ln2_q2f(input int frac);
        return (LN2_Q30 + (64'sd1 <<< (32'sd29 - 32'sd2 * frac))) >>> (32'sd30 - 32'sd2 * frac);
    endfunction

    function automatic longint sat_w(input longint a, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (a > hi) return hi;
        else if (a < lo) return lo;
        else return a;
    endfunction

    function automatic longint shift_round(input longint a, input int sh);
`ifdef UNO_HORNER_ROUND_EN
        return (a + (64'sd1 <<< (sh - 32'sd1))) >>> sh;
`else
        return a >>> sh;
`endif
    endfunction

    // e^n in Q.frac, saturated to w bits; growth is capped once far past saturation
    function automatic longint exp_lut(input int n, input int w, input int frac);
        longint v;
        v = 64'sd1 <<< EXP_Q;
        for (int i = 0; i < n; i++) begin
            if (v < (64'sd1 <<< 40)) v = (v * E_QE) >>> EXP_Q;
        end
        for (int i = 0; i > n; i--) begin
            v = (v * INV_E_QE) >>> EXP_Q;
        end
        return sat_w((v + (64'sd1 <<< (EXP_Q - frac - 32'sd1))) >>> (EXP_Q - frac), w);
    endfunction

endpackage

// File: rtl/uno_range_reduce.sv
// Range reduction for the nonlinear ops: normalises X and derives v, scale, offset, err.
// Rounding of the shared helpers follows UNO_HORNER_ROUND_EN.
module uno_range_reduce
    import uno_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int ACC_W = 2 * WIDTH + 4
) (
    input  op_e                      i_op,
    input  logic signed [WIDTH-1:0]  i_x,
    input  logic signed [WIDTH-1:0]  i_y,
    output logic signed [WIDTH-1:0]  o_v,
    output logic signed [WIDTH-1:0]  o_scale,
    output logic signed [ACC_W-1:0]  o_offset,
    output logic                     o_err
);

    localparam int EXP_N  = 1 << (WIDTH - FRAC);
    localparam int LUT_AW = $clog2(EXP_N + 1);

    // LUT index g covers integer parts g - EXP_N/2; unused top entries saturate
    logic signed [WIDTH-1:0] w_exp_lut [0:(1 << LUT_AW)-1];
    for (genvar g = 0; g < (1 << LUT_AW); g++) begin : g_exp_lut
        assign w_exp_lut[g] = WIDTH'(exp_lut(g - EXP_N / 2, WIDTH, FRAC));
    end

    int                      l_p;
    int                      l_s;
    longint                  l_x;
    longint                  l_y_sh;
    longint                  l_x_norm;
    longint                  l_v_norm;
    logic signed [FRAC-1:0]  l_frac;
    logic [LUT_AW-1:0]       l_idx;
    logic                    l_nonpos;

    // Priority-encode X, normalise into [0.5,1) and select per-op PREP values
    always_comb begin
        l_p = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (i_x[i]) l_p = i;
            else l_p = l_p;
        end
        l_s = (FRAC - 1) - l_p;
        l_x = longint'(i_x);
        if (l_s >= 0) begin
            l_x_norm = l_x <<< l_s;
            l_y_sh   = longint'(i_y) <<< l_s;
        end else begin
            l_x_norm = l_x >>> (-l_s);
            l_y_sh   = longint'(i_y) >>> (-l_s);
        end
        l_v_norm = three_quarters(FRAC) - l_x_norm;
        l_frac   = i_x[FRAC-1:0];
        // Integer part rounded so that X = n + signed frac exactly
        l_idx    = LUT_AW'(int'(l_x >>> FRAC) + int'(i_x[FRAC-1]) + EXP_N / 2);
        l_nonpos = i_x[WIDTH-1] || (i_x == '0);
        case (i_op)
            OP_DIV: begin
                o_v      = WIDTH'(l_v_norm);
                o_scale  = WIDTH'(sat_w(l_y_sh, WIDTH));
                o_offset = '0;
                o_err    = l_nonpos;
            end
            OP_LOG: begin
                o_v      = WIDTH'(l_v_norm);
                o_scale  = WIDTH'(-(64'sd1 <<< FRAC));
                o_offset = ACC_W'(longint'(-l_s) * ln2_q2f(FRAC));
                o_err    = l_nonpos;
            end
            OP_EXP: begin
                o_v      = WIDTH'(l_frac);
                o_scale  = w_exp_lut[l_idx];
                o_offset = '0;
                o_err    = 1'b0;
            end
            default: begin
                o_v      = '0;
                o_scale  = '0;
                o_offset = '0;
                o_err    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uno_horner.sv
// Unified MAC / nonlinear PE: range reduce, Horner polynomial, scale + offset.
// Build option UNO_HORNER_ROUND_EN switches every >>>FRAC to round-half-up.
module uno_horner
    import uno_pkg::*;
#(
    parameter  int WIDTH     = 16,
    parameter  int FRAC      = 12,
    parameter  int NUM_TERMS = 4,
    localparam int ACC_W     = 2 * WIDTH + 4,
    localparam int IDX_W     = $clog2(NUM_TERMS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic signed [WIDTH-1:0]   in_x,
    input  logic signed [WIDTH-1:0]   in_y,
    input  logic signed [2*WIDTH-1:0] in_z,
    input  logic                      in_acc_en,
    input  logic                      cfg_we,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_op,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic signed [WIDTH-1:0]   cfg_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   out_data,
    output logic                      out_err
);

    state_e                    r_state;
    op_e                       r_op;
    logic signed [WIDTH-1:0]   r_x, r_y, r_v, r_scale, r_h;
    logic signed [2*WIDTH-1:0] r_z;
    logic                      r_acc_en, r_err, r_out_valid, r_out_err;
    logic signed [ACC_W-1:0]   r_offset, r_acc, r_out_data;
    logic [IDX_W-1:0]          r_k;
    logic signed [WIDTH-1:0]   r_coef [0:3][0:NUM_TERMS-1];

    logic signed [WIDTH-1:0]   w_v, w_scale, w_h_next;
    logic signed [ACC_W-1:0]   w_offset, w_scale_out, w_mac;
    logic                      w_err;

    uno_range_reduce #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_range_reduce (
        .i_op     (r_op),
        .i_x      (r_x),
        .i_y      (r_y),
        .o_v      (w_v),
        .o_scale  (w_scale),
        .o_offset (w_offset),
        .o_err    (w_err)
    );

    // Horner step, final scale/offset (with error override) and MAC sum
    always_comb begin
        w_h_next = WIDTH'(sat_w(shift_round(longint'(r_h) * longint'(r_v), FRAC)
                                + longint'(r_coef[r_op][r_k]), WIDTH));
        if (r_err) begin
            if (r_op == OP_LOG) w_scale_out = ACC_W'(-(((64'sd1 <<< (WIDTH - 1)) - 64'sd1) <<< FRAC));
            else w_scale_out = ACC_W'(((64'sd1 <<< (WIDTH - 1)) - 64'sd1) <<< FRAC);
        end else begin
            w_scale_out = ACC_W'(longint'(r_h) * longint'(r_scale) + longint'(r_offset));
        end
        if (r_acc_en) w_mac = ACC_W'(longint'(r_x) * longint'(r_y) + longint'(r_acc));
        else w_mac = ACC_W'(longint'(r_x) * longint'(r_y) + longint'(r_z));
    end

    // Sequencer FSM with datapath registers, registered outputs and coefficient bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_MAC;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_acc_en    <= 1'b0;
            r_v         <= '0;
            r_scale     <= '0;
            r_offset    <= '0;
            r_err       <= 1'b0;
            r_h         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
            for (int o = 0; o < 4; o++) begin
                for (int k = 0; k < NUM_TERMS; k++) r_coef[o][k] <= '0;
            end
        end else begin
            // Bank only changes in IDLE, so HORNER always reads a stable set
            if (cfg_we && (r_state == S_IDLE) && (cfg_op != 2'd0) && (int'(cfg_idx) < NUM_TERMS))
                r_coef[cfg_op][cfg_idx] <= cfg_data;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op     <= op_e'(in_op);
                        r_x      <= in_x;
                        r_y      <= in_y;
                        r_z      <= in_z;
                        r_acc_en <= in_acc_en;
                        r_state  <= (op_e'(in_op) == OP_MAC) ? S_EXEC : S_PREP;
                    end
                end
                S_EXEC: begin
                    r_out_data  <= w_mac;
                    r_acc       <= w_mac;
                    r_out_err   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_PREP: begin
                    r_v      <= w_v;
                    r_scale  <= w_scale;
                    r_offset <= w_offset;
                    r_err    <= w_err;
                    r_h      <= r_coef[r_op][NUM_TERMS-1];
                    r_k      <= IDX_W'(NUM_TERMS - 2);
                    r_state  <= S_HORNER;
                end
                S_HORNER: begin
                    r_h <= w_h_next;
                    if (r_k == '0) r_state <= S_SCALE;
                    else r_k <= r_k - IDX_W'(1);
                end
                S_SCALE: begin
                    r_out_data  <= w_scale_out;
                    r_out_err   <= r_err;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign cfg_ready = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_uno_horner.sv
// Directed, table-driven bench for uno_horner (WIDTH=16, FRAC=12, NUM_TERMS=4).
module tb_uno_horner;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, in_acc_en;
    logic [1:0]         in_op;
    logic signed [15:0] in_x, in_y;
    logic signed [31:0] in_z;
    logic               cfg_we, cfg_ready;
    logic [1:0]         cfg_op;
    logic [1:0]         cfg_idx;
    logic signed [15:0] cfg_data;
    logic               out_valid, out_ready, out_err;
    logic signed [35:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uno_horner dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_acc_en(in_acc_en),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    typedef struct {
        logic [1:0]         op;
        logic [15:0]        x;
        logic [15:0]        y;
        logic [31:0]        z;
        logic               acc_en;
        logic signed [35:0] data;
        logic               err;
        int                 lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] op, input logic [1:0] idx, input logic [15:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_op = op; cfg_idx = idx; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                            input logic [31:0] z, input logic acc);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_z = z; in_acc_en = acc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept cycle; lat is where out_valid first shows
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] z, input logic acc,
                          output logic signed [35:0] d, output logic e, output int lat);
        start_op(op, x, y, z, acc);
        wait_valid(lat);
        d = out_data;
        e = out_err;
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [35:0] d;
        logic               e;
        int                 lat;

        vecs[0]  = '{2'd0, 16'h1000, 16'h2000, 32'h0,        1'b0,  36'sh2000000, 1'b0, 2};
        vecs[1]  = '{2'd0, 16'h1000, 16'h1000, 32'h0,        1'b1,  36'sh3000000, 1'b0, 2};
        vecs[2]  = '{2'd0, 16'hF000, 16'h3000, 32'h00500000, 1'b0, -36'sh2B00000, 1'b0, 2};
        vecs[3]  = '{2'd2, 16'h0000, 16'h0000, 32'h0,        1'b0,  36'sh1000000, 1'b0, 6};
        vecs[4]  = '{2'd2, 16'h1000, 16'h0000, 32'h0,        1'b0,  36'sh2B7E000, 1'b0, 6};
        vecs[5]  = '{2'd2, 16'hF000, 16'h0000, 32'h0,        1'b0,  36'sh05E3000, 1'b0, 6};
        vecs[6]  = '{2'd1, 16'h0000, 16'h1000, 32'h0,        1'b0,  36'sh7FFF000, 1'b1, 6};
        vecs[7]  = '{2'd1, 16'h2000, 16'h1000, 32'h0,        1'b0,  36'sh0800000, 1'b0, 6};
        vecs[8]  = '{2'd1, 16'h0400, 16'h1000, 32'h0,        1'b0,  36'sh4000000, 1'b0, 6};
        vecs[9]  = '{2'd1, 16'h0100, 16'h7000, 32'h0,        1'b0,  36'shFFFE000, 1'b0, 6};
        vecs[10] = '{2'd1, 16'hF000, 16'h1000, 32'h0,        1'b0,  36'sh7FFF000, 1'b1, 6};
        vecs[11] = '{2'd3, 16'h0800, 16'h0000, 32'h0,        1'b0, -36'sh0400000, 1'b0, 6};
        vecs[12] = '{2'd3, 16'h0000, 16'h0000, 32'h0,        1'b0, -36'sh7FFF000, 1'b1, 6};
        vecs[13] = '{2'd0, 16'h0000, 16'h0000, 32'h0,        1'b1, -36'sh2B00000, 1'b0, 2};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_x = '0; in_y = '0; in_z = '0;
        in_acc_en = 1'b0; cfg_we = 1'b0; cfg_op = 2'd0; cfg_idx = 2'd0; cfg_data = '0;
        out_ready = 1'b0;
        #22;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 36'sd0);
        check("reset_out_err", out_err, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        cfg_write(2'd2, 2'd0, 16'h1000);
        cfg_write(2'd2, 2'd1, 16'h1000);
        cfg_write(2'd1, 2'd0, 16'h2000);
        cfg_write(2'd3, 2'd1, 16'h1000);
        cfg_write(2'd0, 2'd0, 16'h7777);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].acc_en, d, e, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].data);
            check($sformatf("vec%0d_err", i), e, vecs[i].err);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // LOG X=1.0: v=0.25, h=0.25, out = -0.25 + ln2 (one LSB slack on the constant)
        run_op(2'd3, 16'h1000, 16'h0, 32'h0, 1'b0, d, e, lat);
        n_checks++;
        if (d < 36'sd7434775 || d > 36'sd7434777) begin
            n_errors++;
            $display("FAIL log_ln2_offset: got %0d expected 7434776 +/- 1", d);
        end

        // Held result under back-pressure, with a coefficient write that must be dropped
        start_op(2'd2, 16'h0000, 16'h0, 32'h0, 1'b0);
        wait_valid(lat);
        check("stall_latency", lat, 6);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                cfg_we = 1'b1; cfg_op = 2'd2; cfg_idx = 2'd0; cfg_data = 16'h2000;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            check($sformatf("stall%0d_valid", c), out_valid, 1'b1);
            check($sformatf("stall%0d_data", c), out_data, 36'sh1000000);
            check($sformatf("stall%0d_err", c), out_err, 1'b0);
            check($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
            check($sformatf("stall%0d_cfg_ready", c), cfg_ready, 1'b0);
        end
        consume();
        check("after_consume_in_ready", in_ready, 1'b1);
        run_op(2'd2, 16'h0000, 16'h0, 32'h0, 1'b0, d, e, lat);
        check("busy_cfg_dropped", d, 36'sh1000000);

        // Asynchronous reset in the middle of HORNER
        start_op(2'd2, 16'h0000, 16'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("mid_busy_in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_out_data", out_data, 36'sd0);
        check("mid_reset_in_ready", in_ready, 1'b1);
        check("mid_reset_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd2, 16'h0000, 16'h0, 32'h0, 1'b0, d, e, lat);
        check("post_reset_exp_bank_cleared", d, 36'sd0);
        check("post_reset_exp_latency", lat, 6);
        run_op(2'd0, 16'h0000, 16'h0000, 32'h0, 1'b1, d, e, lat);
        check("post_reset_acc_cleared", d, 36'sd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
